// File: rtl/gray_step_pkg.sv
// Shared definitions for the Gray step monitor: default sizes, FSM state
// encoding and a width-independent Gray-to-binary helper.
package gray_step_pkg;

    localparam int DEF_WIDTH       = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_ERR_CNT_W   = 8;

    localparam logic [1:0] FILL_ENC  = 2'd0;
    localparam logic [1:0] ARM_ENC   = 2'd1;
    localparam logic [1:0] TRACK_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_FILL  = FILL_ENC,
        ST_ARM   = ARM_ENC,
        ST_TRACK = TRACK_ENC
    } state_e;

    // Each binary bit is the XOR of all Gray bits at or above it. Unused
    // upper bits must be zero, which lets one function serve any width.
    function automatic logic [31:0] gray_to_bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int k = 1; k < 32; k++) begin
            b = b ^ (g >> k);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_step_monitor_gray_decoder.sv
// Combinational Gray-to-binary decoder; exact inverse of bin ^ (bin >> 1).
module gray_decoder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    // Reduce over the slice above each bit so no output bit feeds another.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign bin_o[gi] = ^gray_i[WIDTH-1:gi];
        end
    endgenerate

endmodule

// File: rtl/gray_step_monitor.sv
// Gray step monitor: synchronises an asynchronous Gray bus, decodes it and
// classifies each change as a legal +1/-1 step or an illegal jump.
// Optional feature macro: GRAY_STEP_WRAP_FLAG_EN adds a 'wrap' pulse output
// on legal all-ones <-> zero transitions.
module gray_step_monitor
    import gray_step_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int ERR_CNT_W   = DEF_ERR_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     gray_in,
    output logic [WIDTH-1:0]     bin_out,
    output logic                 bin_valid,
    output logic                 dir_up,
    output logic                 step_err,
    output logic [ERR_CNT_W-1:0] err_count,
`ifdef GRAY_STEP_WRAP_FLAG_EN
    output logic                 wrap,
`endif
    output logic                 ready
);

    localparam int FILL_W = $clog2(SYNC_STAGES) + 1;
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(SYNC_STAGES - 1);
    localparam logic [WIDTH-1:0]  STEP_ONE  = WIDTH'(1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]     g_s;
    logic [WIDTH-1:0]     b_dec;
    logic [WIDTH-1:0]     delta;

    state_e               state_q,  state_d;
    logic [FILL_W-1:0]    fill_q,   fill_d;
    logic [WIDTH-1:0]     prev_q,   prev_d;
    logic [WIDTH-1:0]     bin_q,    bin_d;
    logic                 valid_q,  valid_d;
    logic                 dir_q,    dir_d;
    logic                 err_q,    err_d;
    logic [ERR_CNT_W-1:0] cnt_q,    cnt_d;
    logic                 ready_q,  ready_d;
    logic                 wrap_q,   wrap_d;

    // Input synchroniser: shift gray_in through SYNC_STAGES flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else if (SYNC_STAGES > 1) begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], gray_in};
        end else begin
            sync_q <= gray_in;
        end
    end

    assign g_s = sync_q[SYNC_STAGES-1];

    gray_decoder #(.WIDTH(WIDTH)) u_dec (
        .gray_i (g_s),
        .bin_o  (b_dec)
    );

    // Next-state and output decisions: fill, arm baseline, then classify steps.
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        prev_d  = prev_q;
        bin_d   = bin_q;
        valid_d = 1'b0;
        dir_d   = dir_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        wrap_d  = 1'b0;
        delta   = b_dec - prev_q;
        case (state_q)
            ST_FILL: begin
                if (fill_q == FILL_LAST) begin
                    fill_d  = '0;
                    state_d = ST_ARM;
                end else begin
                    fill_d = fill_q + FILL_W'(1);
                end
            end
            ST_ARM: begin
                prev_d  = b_dec;
                bin_d   = b_dec;
                ready_d = 1'b1;
                state_d = ST_TRACK;
            end
            ST_TRACK: begin
                if (delta != '0) begin
                    // Every change resyncs the baseline, legal or not.
                    prev_d = b_dec;
                    bin_d  = b_dec;
                    if (delta == STEP_ONE) begin
                        valid_d = 1'b1;
                        dir_d   = 1'b1;
                        wrap_d  = (b_dec == '0);
                    end else if (delta == '1) begin
                        valid_d = 1'b1;
                        dir_d   = 1'b0;
                        wrap_d  = (b_dec == '1);
                    end else begin
                        err_d = 1'b1;
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + ERR_CNT_W'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = ST_FILL;
                fill_d  = '0;
            end
        endcase
    end

    // State and registered outputs; reset discards the baseline entirely.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FILL;
            fill_q  <= '0;
            prev_q  <= '0;
            bin_q   <= '0;
            valid_q <= 1'b0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            prev_q  <= prev_d;
            bin_q   <= bin_d;
            valid_q <= valid_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bin_out   = bin_q;
    assign bin_valid = valid_q;
    assign dir_up    = dir_q;
    assign step_err  = err_q;
    assign err_count = cnt_q;
    assign ready     = ready_q;

`ifdef GRAY_STEP_WRAP_FLAG_EN
    assign wrap = wrap_q;
`else
    logic unused_wrap;
    assign unused_wrap = wrap_q;
`endif

endmodule
